io_mmio_fifo: RTL

Memory-mapped I/O block that sits beside the CPU data-memory path at the MMIO base address. It provides buffered UART RX and TX through parametrised FIFOs, cycle and retired-instruction counters, and a status/sticky-error register. The existing uart module is instantiated internally. The CPU sees single-cycle combinational reads, with side effects committed on the clock edge.

---
 rtl/io_mmio_fifo_pkg.sv | 40 ++++
 rtl/io_mmio_fifo_fifo.sv | 48 ++++
 rtl/uart.sv | 96 +++++++++
 rtl/io_mmio_fifo.sv | 103 ++++++++++
 4 files changed

// File: rtl/io_mmio_fifo_pkg.sv
// Shared register map, STATUS bit layout and address decode for the MMIO I/O block.
package io_mmio_fifo_pkg;

    localparam logic [31:0] OFF_STATUS  = 32'h00;
    localparam logic [31:0] OFF_RX_DATA = 32'h04;
    localparam logic [31:0] OFF_TX_DATA = 32'h08;
    localparam logic [31:0] OFF_CYCLE   = 32'h10;
    localparam logic [31:0] OFF_INSTR   = 32'h14;
    localparam logic [31:0] OFF_CNT_RST = 32'h18;

    localparam int ST_TX_NOT_FULL  = 0;
    localparam int ST_RX_NOT_EMPTY = 1;
    localparam int ST_TX_DROP      = 2;
    localparam int ST_RX_COUNT_LSB = 8;
    localparam int ST_TX_COUNT_LSB = 16;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_STATUS,
        REG_RX_DATA,
        REG_TX_DATA,
        REG_CYCLE,
        REG_INSTR,
        REG_CNT_RST
    } reg_sel_e;

    // Full-word compare against the base plus each fixed offset; anything else is unmapped.
    function automatic reg_sel_e decode_addr(input logic [31:0] addr, input logic [31:0] base);
        reg_sel_e sel;
        sel = REG_NONE;
        if (addr == base + OFF_STATUS)       sel = REG_STATUS;
        else if (addr == base + OFF_RX_DATA) sel = REG_RX_DATA;
        else if (addr == base + OFF_TX_DATA) sel = REG_TX_DATA;
        else if (addr == base + OFF_CYCLE)   sel = REG_CYCLE;
        else if (addr == base + OFF_INSTR)   sel = REG_INSTR;
        else if (addr == base + OFF_CNT_RST) sel = REG_CNT_RST;
        return sel;
    endfunction

endpackage

// File: rtl/io_mmio_fifo_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = wptr - rptr;
    assign full    = (count == DEPTH_COUNT);
    assign empty   = (count == '0);
    assign dout    = mem[rptr[AW-1:0]];

    // Storage array needs no reset; only entries between the pointers are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

    // Pointers advance independently so a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart.sv
// 8N1 UART with valid/ready byte interfaces; the received byte is held until the consumer accepts it.
module uart #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    input  logic       serial_in,
    output logic       serial_out
);
    localparam int SYMBOL = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(SYMBOL) + 1;
    localparam logic [CW-1:0] SYMBOL_LAST  = CW'(SYMBOL - 1);
    localparam logic [CW-1:0] SAMPLE_POINT = CW'(SYMBOL / 2);

    logic [9:0]    tx_shift;
    logic [3:0]    tx_bits;
    logic [CW-1:0] tx_cnt;
    logic          tx_busy;

    logic [1:0]    rx_sync;
    logic [9:0]    rx_shift;
    logic [3:0]    rx_bits;
    logic [CW-1:0] rx_cnt;
    logic          rx_busy;
    logic          rx_hold;

    assign data_in_ready  = !tx_busy;
    assign serial_out     = tx_busy ? tx_shift[0] : 1'b1;
    assign data_out       = rx_shift[8:1];
    assign data_out_valid = rx_hold;

    // Transmitter shifts start, eight data bits LSB first, then stop, one symbol period each.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_busy  <= 1'b0;
            tx_shift <= '1;
            tx_bits  <= '0;
            tx_cnt   <= '0;
        end else if (!tx_busy) begin
            if (data_in_valid) begin
                tx_busy  <= 1'b1;
                tx_shift <= {1'b1, data_in, 1'b0};
                tx_bits  <= '0;
                tx_cnt   <= SYMBOL_LAST;
            end
        end else if (tx_cnt == '0) begin
            tx_cnt   <= SYMBOL_LAST;
            tx_shift <= {1'b1, tx_shift[9:1]};
            if (tx_bits == 4'd9) tx_busy <= 1'b0;
            else                 tx_bits <= tx_bits + 4'd1;
        end else begin
            tx_cnt <= tx_cnt - 1'b1;
        end
    end

    // Receiver samples mid-symbol after a falling start edge; no new frame starts while a byte is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync  <= 2'b11;
            rx_shift <= '0;
            rx_bits  <= '0;
            rx_cnt   <= '0;
            rx_busy  <= 1'b0;
            rx_hold  <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], serial_in};
            if (rx_hold && data_out_ready) rx_hold <= 1'b0;
            if (!rx_busy) begin
                if (!rx_hold && !rx_sync[1]) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= SAMPLE_POINT;
                    rx_bits <= '0;
                end
            end else if (rx_cnt == '0) begin
                rx_shift <= {rx_sync[1], rx_shift[9:1]};
                rx_cnt   <= SYMBOL_LAST;
                if (rx_bits == 4'd9) begin
                    rx_busy <= 1'b0;
                    rx_hold <= 1'b1;
                end else begin
                    rx_bits <= rx_bits + 4'd1;
                end
            end else begin
                rx_cnt <= rx_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_mmio_fifo.sv
// MMIO block: buffered UART RX/TX, cycle and retired-instruction counters, STATUS with sticky drop flag.
module io_mmio_fifo #(
    parameter int          CPU_CLOCK_FREQ = 50_000_000,
    parameter int          BAUD_RATE      = 115200,
    parameter int          RX_FIFO_DEPTH  = 8,
    parameter int          TX_FIFO_DEPTH  = 8,
    parameter int          CNT_WIDTH      = 32,
    parameter logic [31:0] MMIO_BASE      = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        serial_in,
    output logic        serial_out,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic        instr_retire,
    input  logic        instr_is_nop,
    output logic [31:0] rdata
);
    import io_mmio_fifo_pkg::*;

    localparam int RX_CW = $clog2(RX_FIFO_DEPTH) + 1;
    localparam int TX_CW = $clog2(TX_FIFO_DEPTH) + 1;

    reg_sel_e             sel;
    logic                 uart_reset;
    logic [7:0]           rx_byte, rx_head, tx_head;
    logic                 rx_valid, rx_full, rx_empty;
    logic                 tx_ready, tx_full, tx_empty;
    logic [RX_CW-1:0]     rx_count;
    logic [TX_CW-1:0]     tx_count;
    logic                 tx_push, tx_drop, drop_now;
    logic [CNT_WIDTH-1:0] cycle_cnt, instr_cnt;
    logic [31:0]          status_word;

    assign sel        = decode_addr(addr, MMIO_BASE);
    assign uart_reset = !rst_n;
    assign tx_push    = we && (sel == REG_TX_DATA);
    assign drop_now   = tx_push && tx_full;

    uart #(.CLOCK_FREQ(CPU_CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_uart (
        .clk(clk), .reset(uart_reset),
        .data_in(tx_head), .data_in_valid(!tx_empty), .data_in_ready(tx_ready),
        .data_out(rx_byte), .data_out_valid(rx_valid), .data_out_ready(!rx_full),
        .serial_in(serial_in), .serial_out(serial_out)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n),
        .push(rx_valid), .din(rx_byte),
        .pop(re && (sel == REG_RX_DATA)), .dout(rx_head),
        .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n),
        .push(tx_push), .din(wdata[7:0]),
        .pop(!tx_empty && tx_ready), .dout(tx_head),
        .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    // Counter clear takes priority over the increment happening in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (we && (sel == REG_CNT_RST)) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
            if (instr_retire && !instr_is_nop) instr_cnt <= instr_cnt + CNT_WIDTH'(1);
        end
    end

    // Sticky drop flag: a drop in the same cycle as a STATUS store keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           tx_drop <= 1'b0;
        else if (drop_now)                    tx_drop <= 1'b1;
        else if (we && (sel == REG_STATUS))   tx_drop <= 1'b0;
    end

    // STATUS word assembly and the combinational read mux.
    always_comb begin
        status_word                              = '0;
        status_word[ST_TX_NOT_FULL]              = !tx_full;
        status_word[ST_RX_NOT_EMPTY]             = !rx_empty;
        status_word[ST_TX_DROP]                  = tx_drop;
        status_word[ST_RX_COUNT_LSB +: 8]        = 8'(rx_count);
        status_word[ST_TX_COUNT_LSB +: 8]        = 8'(tx_count);
        rdata = '0;
        case (sel)
            REG_STATUS:  rdata = status_word;
            REG_RX_DATA: rdata = rx_empty ? 32'h0 : {24'h0, rx_head};
            REG_CYCLE:   rdata = 32'(cycle_cnt);
            REG_INSTR:   rdata = 32'(instr_cnt);
            default:     rdata = '0;
        endcase
    end

endmodule
